// File: rtl/gnor_vec.sv
// rtl/gnor_vec.sv - NIN-operand bitwise gate reduction through a two-stage valid/ready pipeline
module gnor_vec #(
  parameter int WIDTH = 8,
  parameter int NIN   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NIN*WIDTH-1:0]           in_data,
  input  logic [2:0]                     in_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [$clog2(WIDTH+1)-1:0]     out_ones,
  output logic                           out_err
);

  localparam int OW = $clog2(WIDTH + 1);

  logic                 s1_valid;
  logic [NIN*WIDTH-1:0] s1_data;
  logic [2:0]           s1_mode;
  logic                 s2_valid;
  logic [WIDTH-1:0]     s2_data;
  logic [OW-1:0]        s2_ones;
  logic                 s2_err;

  logic                 s1_to_s2;
  logic                 accept;
  logic [WIDTH-1:0]     red_or;
  logic [WIDTH-1:0]     red_and;
  logic [WIDTH-1:0]     red_xor;
  logic [WIDTH-1:0]     result;
  logic [OW-1:0]        ones;
  logic                 err;

  assign s1_to_s2 = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !s1_valid || !s2_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    red_or  = '0;
    red_and = '1;
    red_xor = '0;
    for (int k = 0; k < NIN; k++) begin
      red_or  = red_or  | s1_data[k*WIDTH +: WIDTH];
      red_and = red_and & s1_data[k*WIDTH +: WIDTH];
      red_xor = red_xor ^ s1_data[k*WIDTH +: WIDTH];
    end
    err = 1'b0;
    case (s1_mode)
      3'd0:    result = ~red_or;
      3'd1:    result = red_or;
      3'd2:    result = ~red_and;
      3'd3:    result = red_and;
      3'd4:    result = red_xor;
      3'd5:    result = ~red_xor;
      default: begin
        result = '0;
        err    = 1'b1;
      end
    endcase
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + OW'(result[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
      s1_mode  <= in_mode;
    end else if (s1_to_s2) begin
      s1_valid <= 1'b0;
    end
  end

  // Result fields only change on a reload, so they hold steady through a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_ones  <= '0;
      s2_err   <= 1'b0;
    end else if (s1_to_s2) begin
      s2_valid <= 1'b1;
      s2_data  <= result;
      s2_ones  <= ones;
      s2_err   <= err;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_ones  = s2_ones;
  assign out_err   = s2_err;

endmodule

// File: tb/tb_gnor_vec.sv
// tb/tb_gnor_vec.sv - directed vector bench for gnor_vec in three configurations
module tb_gnor_vec;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // a: WIDTH=8 NIN=2, b: WIDTH=8 NIN=4, c: WIDTH=1 NIN=2
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [15:0] a_in_data;
  logic [2:0]  a_in_mode;
  logic [7:0]  a_out_data;
  logic [3:0]  a_out_ones;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [31:0] b_in_data;
  logic [2:0]  b_in_mode;
  logic [7:0]  b_out_data;
  logic [3:0]  b_out_ones;

  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_err;
  logic [1:0]  c_in_data;
  logic [2:0]  c_in_mode;
  logic [0:0]  c_out_data;
  logic [0:0]  c_out_ones;

  gnor_vec #(.WIDTH(8), .NIN(2)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_mode(a_in_mode), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_ones(a_out_ones),
    .out_err(a_out_err));

  gnor_vec #(.WIDTH(8), .NIN(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_mode(b_in_mode), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_ones(b_out_ones),
    .out_err(b_out_err));

  gnor_vec #(.WIDTH(1), .NIN(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_mode(c_in_mode), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .out_ones(c_out_ones),
    .out_err(c_out_err));

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] data;
    logic [7:0]  exp_data;
    logic [3:0]  exp_ones;
    logic        exp_err;
  } vec_t;

  vec_t tab [3][10];
  int   n_tab [3];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input int sel, input logic v, input logic [2:0] m, input logic [31:0] d);
    case (sel)
      0: begin a_in_valid = v; a_in_mode = m; a_in_data = d[15:0]; end
      1: begin b_in_valid = v; b_in_mode = m; b_in_data = d; end
      default: begin c_in_valid = v; c_in_mode = m; c_in_data = d[1:0]; end
    endcase
  endtask

  // Back-to-back stream: vector j-2 must be on the output in iteration j.
  task automatic run_tab(input int sel);
    logic       v, e;
    logic [7:0] d;
    logic [3:0] o;
    for (int j = 0; j < n_tab[sel] + 2; j++) begin
      @(posedge clk); #1;
      if (j < n_tab[sel]) drive(sel, 1'b1, tab[sel][j].mode, tab[sel][j].data);
      else drive(sel, 1'b0, 3'd0, 32'd0);
      @(negedge clk);
      case (sel)
        0: begin v = a_out_valid; d = a_out_data; o = a_out_ones; e = a_out_err; end
        1: begin v = b_out_valid; d = b_out_data; o = b_out_ones; e = b_out_err; end
        default: begin v = c_out_valid; d = {7'd0, c_out_data}; o = {3'd0, c_out_ones}; e = c_out_err; end
      endcase
      if (j >= 2) begin
        chk($sformatf("t%0d[%0d].valid", sel, j-2), 64'(v), 64'(1'b1));
        chk($sformatf("t%0d[%0d].data", sel, j-2), 64'(d), 64'(tab[sel][j-2].exp_data));
        chk($sformatf("t%0d[%0d].ones", sel, j-2), 64'(o), 64'(tab[sel][j-2].exp_ones));
        chk($sformatf("t%0d[%0d].err", sel, j-2), 64'(e), 64'(tab[sel][j-2].exp_err));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sent, got, occ, nxt;
    logic acc, emit, prev_stall;
    logic [7:0] prev_data;

    tab[0][0] = '{3'd0, 32'h0000330F, 8'hC0, 4'd2, 1'b0};
    tab[0][1] = '{3'd1, 32'h00003CF0, 8'hFC, 4'd6, 1'b0};
    tab[0][2] = '{3'd3, 32'h00003CF0, 8'h30, 4'd2, 1'b0};
    tab[0][3] = '{3'd4, 32'h00003CF0, 8'hCC, 4'd4, 1'b0};
    tab[0][4] = '{3'd5, 32'h00003CF0, 8'h33, 4'd4, 1'b0};
    tab[0][5] = '{3'd2, 32'h00003CF0, 8'hCF, 4'd6, 1'b0};
    tab[0][6] = '{3'd6, 32'h0000A55A, 8'h00, 4'd0, 1'b1};
    tab[0][7] = '{3'd7, 32'h0000FFFF, 8'h00, 4'd0, 1'b1};
    tab[0][8] = '{3'd0, 32'h00000000, 8'hFF, 4'd8, 1'b0};
    tab[0][9] = '{3'd3, 32'h0000FFFF, 8'hFF, 4'd8, 1'b0};
    n_tab[0] = 10;
    tab[1][0] = '{3'd2, 32'h7EFFFFFF, 8'h81, 4'd2, 1'b0};
    tab[1][1] = '{3'd6, 32'h12345678, 8'h00, 4'd0, 1'b1};
    tab[1][2] = '{3'd4, 32'h08040201, 8'h0F, 4'd4, 1'b0};
    tab[1][3] = '{3'd0, 32'h00000001, 8'hFE, 4'd7, 1'b0};
    tab[1][4] = '{3'd3, 32'hFFFFFFFF, 8'hFF, 4'd8, 1'b0};
    n_tab[1] = 5;
    tab[2][0] = '{3'd0, 32'h0, 8'h1, 4'd1, 1'b0};
    tab[2][1] = '{3'd0, 32'h1, 8'h0, 4'd0, 1'b0};
    tab[2][2] = '{3'd0, 32'h2, 8'h0, 4'd0, 1'b0};
    tab[2][3] = '{3'd0, 32'h3, 8'h0, 4'd0, 1'b0};
    n_tab[2] = 4;

    rst = 1'b1;
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 3'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.out_valid", 64'(a_out_valid), 64'd0);
    chk("rst.out_data", 64'(a_out_data), 64'd0);
    chk("rst.out_ones", 64'(a_out_ones), 64'd0);
    chk("rst.out_err", 64'(a_out_err), 64'd0);
    chk("rst.in_ready", 64'(a_in_ready), 64'd1);
    chk("rst.b_out_valid", 64'(b_out_valid), 64'd0);

    for (int s = 0; s < 3; s++) run_tab(s);

    // Backpressure stream of 1..10 with a small occupancy model for in_ready.
    sent = 0; got = 0; occ = 0; prev_stall = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
      @(posedge clk); #1;
      a_out_ready = 1'($urandom_range(0, 1));
      if (sent < 10) drive(0, 1'b1, 3'd1, 32'(sent + 1));
      else drive(0, 1'b0, 3'd0, 32'd0);
      @(negedge clk);
      chk("bp.in_ready", 64'(a_in_ready), 64'(!(occ == 2 && !a_out_ready)));
      if (prev_stall) chk("bp.stall_data", 64'(a_out_data), 64'(prev_data));
      acc  = a_in_valid && a_in_ready;
      emit = a_out_valid && a_out_ready;
      if (emit) begin
        nxt = got + 1;
        chk("bp.order", 64'(a_out_data), 64'(nxt));
        got++;
      end
      prev_stall = a_out_valid && !a_out_ready;
      prev_data  = a_out_data;
      occ = occ + int'(acc) - int'(emit);
      if (acc) sent++;
    end
    chk("bp.count", 64'(got), 64'd10);
    @(posedge clk); #1 drive(0, 1'b0, 3'd0, 32'd0);
    a_out_ready = 1'b1;
    repeat (3) @(posedge clk);

    // Fill both stages, reset with input still offered, then confirm nothing leaks out.
    #1 a_out_ready = 1'b0;
    drive(0, 1'b1, 3'd1, 32'h00AA);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("full.in_ready", 64'(a_in_ready), 64'd0);
    chk("full.out_valid", 64'(a_out_valid), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    drive(0, 1'b1, 3'd1, 32'h0055);
    @(posedge clk); #1 rst = 1'b0;
    drive(0, 1'b0, 3'd0, 32'd0);
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("mrst.out_valid", 64'(a_out_valid), 64'd0);
    chk("mrst.out_data", 64'(a_out_data), 64'd0);
    chk("mrst.in_ready", 64'(a_in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mrst.drain%0d", k), 64'(a_out_valid), 64'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
